// File: rtl/lcd_pkg.sv
// lcd_pkg -- shared definitions for the LCD host command sequencer.
//
// Contents:
//   CMD_*          host/LCD command codes (display, load, four shifts)
//   IMG_BYTES      number of image bytes streamed from ROM on a load
//   LAST_ADDR      ROM address of the final image byte
//   lcd_state_t    sequencer FSM state encoding
//   is_legal_cmd   true for the six defined command codes (0..5)
package lcd_pkg;

    localparam logic [2:0] CMD_DISP  = 3'd0;
    localparam logic [2:0] CMD_LOAD  = 3'd1;
    localparam logic [2:0] CMD_RIGHT = 3'd2;
    localparam logic [2:0] CMD_LEFT  = 3'd3;
    localparam logic [2:0] CMD_UP    = 3'd4;
    localparam logic [2:0] CMD_DOWN  = 3'd5;

    localparam int         IMG_BYTES = 36;
    localparam logic [5:0] LAST_ADDR = 6'(IMG_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } lcd_state_t;

    function automatic logic is_legal_cmd(input logic [2:0] code);
        return (code <= CMD_DOWN);
    endfunction

endpackage

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo -- small command queue between the host and the sequencer FSM.
//
// Ports:
//   clk, reset   single clock, synchronous active-high reset (empties queue)
//   push, din    write din at the tail (ignored while full)
//   pop          drop the head entry (ignored while empty)
//   dout         head entry, combinational from registered storage
//   full, empty  occupancy flags
//
// FIFO_DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module lcd_cmd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [DATA_W-1:0] mem_reg [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;

    logic do_push;
    logic do_pop;

    assign full    = (count_reg == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_reg[rd_ptr_reg];

    // Storage carries no reset: an entry is only ever read after being written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lcd_host_seq.sv
// lcd_host_seq -- queues host commands and sequences them to an LCD controller.
//
// A command is issued (single-cycle cmd_valid) only from IDLE when the queue
// holds something and the controller is not busy. A load additionally streams
// the 36-byte image: rom_addr 0..35 over the issue cycle and the following
// 35 cycles, with ROM data passed straight through to datain. After every
// command the FSM waits for busy to rise and then fall before issuing again.
//
// Ports:
//   clk, reset                  single clock, synchronous active-high reset
//   host_cmd, host_cmd_valid    host command offer
//   host_cmd_ready              queue not full (push = valid && ready)
//   rom_rd, rom_addr, rom_data  image ROM interface (data one cycle after rd)
//   cmd, cmd_valid, datain      command / image byte to the LCD controller
//   busy                        LCD controller busy flag
//   seq_idle                    queue empty and FSM in IDLE
//   cmd_err                     only with LCD_HOST_SEQ_CMD_FILTER_EN: pulses the
//                               cycle after a push of code 6 or 7, which is
//                               dropped instead of queued
//
// Optional feature macro: LCD_HOST_SEQ_CMD_FILTER_EN
module lcd_host_seq
    import lcd_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_cmd_valid,
    output logic       host_cmd_ready,
    output logic       rom_rd,
    output logic [5:0] rom_addr,
    input  logic [7:0] rom_data,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    output logic [7:0] datain,
    input  logic       busy,
    output logic       seq_idle
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
    ,
    output logic       cmd_err
`endif
);

    lcd_state_t state_reg;
    lcd_state_t state_next;
    logic [5:0] load_cnt_reg;
    logic [5:0] load_cnt_next;

    logic       push_fire;
    logic       fifo_push;
    logic       fifo_pop;
    logic [2:0] fifo_head;
    logic       fifo_full;
    logic       fifo_empty;

    assign host_cmd_ready = !fifo_full;
    assign push_fire      = host_cmd_valid && host_cmd_ready;

`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
    logic cmd_err_reg;
    logic cmd_illegal;

    // Illegal codes are accepted (ready is unaffected) but never stored.
    assign cmd_illegal = !is_legal_cmd(host_cmd);
    assign fifo_push   = push_fire && !cmd_illegal;
    assign cmd_err     = cmd_err_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_err_reg <= 1'b0;
        end else begin
            cmd_err_reg <= push_fire && cmd_illegal;
        end
    end
`else
    assign fifo_push = push_fire;
`endif

    lcd_cmd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (3)
    ) u_cmd_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (host_cmd),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            load_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            load_cnt_reg <= load_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        load_cnt_next = load_cnt_reg;
        cmd_valid     = 1'b0;
        cmd           = CMD_DISP;
        rom_rd        = 1'b0;
        rom_addr      = '0;
        fifo_pop      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty && !busy) begin
                    cmd_valid = 1'b1;
                    cmd       = fifo_head;
                    fifo_pop  = 1'b1;
                    if (fifo_head == CMD_LOAD) begin
                        // Address 0 goes out in the issue cycle itself, so
                        // the LOAD state continues from address 1.
                        rom_rd        = 1'b1;
                        rom_addr      = '0;
                        load_cnt_next = 6'd1;
                        state_next    = LOAD;
                    end else begin
                        state_next = WAIT_HI;
                    end
                end
            end

            LOAD: begin
                rom_rd   = 1'b1;
                rom_addr = load_cnt_reg;
                if (load_cnt_reg == LAST_ADDR) begin
                    load_cnt_next = '0;
                    state_next    = WAIT_HI;
                end else begin
                    load_cnt_next = load_cnt_reg + 6'd1;
                end
            end

            // Busy is ignored during LOAD; the handshake starts afterwards.
            WAIT_HI: begin
                if (busy) begin
                    state_next = WAIT_LO;
                end
            end

            WAIT_LO: begin
                if (!busy) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign datain   = rom_data;
    assign seq_idle = fifo_empty && (state_reg == IDLE);

endmodule

// File: tb/tb_lcd_host_seq.sv
module tb_lcd_host_seq;
    import lcd_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] host_cmd;
    logic       host_cmd_valid;
    logic       host_cmd_ready;
    logic       rom_rd;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic [7:0] datain;
    logic       busy;
    logic       seq_idle;
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
    logic       cmd_err;
`endif

    logic [7:0] rom_mem [IMG_BYTES];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lcd_host_seq #(.FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .host_cmd       (host_cmd),
        .host_cmd_valid (host_cmd_valid),
        .host_cmd_ready (host_cmd_ready),
        .rom_rd         (rom_rd),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .cmd            (cmd),
        .cmd_valid      (cmd_valid),
        .datain         (datain),
        .busy           (busy),
        .seq_idle       (seq_idle)
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
        ,
        .cmd_err        (cmd_err)
`endif
    );

    // Image ROM: registered read, data valid the cycle after rom_rd.
    always @(posedge clk) begin
        if (rom_rd && rom_addr < 6'(IMG_BYTES)) rom_data <= rom_mem[rom_addr];
        else                                    rom_data <= 8'h00;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; host_cmd_valid = 1'b0; host_cmd = CMD_DISP; busy = 1'b1;
        tick(); tick();
        reset = 1'b0; host_cmd_valid = 1'b1; host_cmd = CMD_RIGHT;
        tick(); tick();
        host_cmd_valid = 1'b0; #1;
        n_tests++; if (seq_idle !== 1'b0) begin n_fail++; $display("FAIL pre_reset_queue: seq_idle=%0b required 0", seq_idle); end
        reset = 1'b1;
        tick();
        reset = 1'b0; busy = 1'b0; #1;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %0b required 0", cmd_valid); end
        n_tests++; if (cmd !== 3'd0) begin n_fail++; $display("FAIL reset_cmd: got %0d required 0", cmd); end
        n_tests++; if (rom_rd !== 1'b0) begin n_fail++; $display("FAIL reset_rom_rd: got %0b required 0", rom_rd); end
        n_tests++; if (rom_addr !== 6'd0) begin n_fail++; $display("FAIL reset_rom_addr: got %0d required 0", rom_addr); end
        n_tests++; if (host_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b required 1", host_cmd_ready); end
        n_tests++; if (seq_idle !== 1'b1) begin n_fail++; $display("FAIL reset_seq_idle: got %0b required 1", seq_idle); end
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %0b required 0", cmd_err); end
`endif
        tick(); #1;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_discard: cmd_valid=%0b required 0", cmd_valid); end
        $display("[TB] reset done");
    endtask

    task automatic test_load();
        busy = 1'b0; host_cmd = CMD_LOAD; host_cmd_valid = 1'b1; #1;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL load_same_cycle: cmd_valid=%0b required 0", cmd_valid); end
        tick();
        host_cmd_valid = 1'b0; #1;
        n_tests++; if (cmd_valid !== 1'b1 || cmd !== CMD_LOAD) begin n_fail++; $display("FAIL load_issue: valid=%0b cmd=%0d required 1/1", cmd_valid, cmd); end
        n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 6'd0) begin n_fail++; $display("FAIL load_addr0: rd=%0b addr=%0d required 1/0", rom_rd, rom_addr); end
        $display("[TB] load issued");
        for (int k = 1; k < IMG_BYTES; k++) begin
            tick(); #1;
            n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 6'(k)) begin n_fail++; $display("FAIL load_addr: rd=%0b addr=%0d required 1/%0d", rom_rd, rom_addr, k); end
            n_tests++; if (datain !== rom_mem[k-1]) begin n_fail++; $display("FAIL load_data: byte %0d got %02h required %02h", k-1, datain, rom_mem[k-1]); end
            n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL load_no_issue: cmd_valid=%0b required 0", cmd_valid); end
        end
        tick(); #1;
        n_tests++; if (datain !== rom_mem[IMG_BYTES-1]) begin n_fail++; $display("FAIL load_last_data: got %02h required %02h", datain, rom_mem[IMG_BYTES-1]); end
        n_tests++; if (rom_rd !== 1'b0 || rom_addr !== 6'd0) begin n_fail++; $display("FAIL load_end: rd=%0b addr=%0d required 0/0", rom_rd, rom_addr); end
        n_tests++; if (seq_idle !== 1'b0) begin n_fail++; $display("FAIL load_wait: seq_idle=%0b required 0", seq_idle); end
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        tick(); #1;
        n_tests++; if (seq_idle !== 1'b1) begin n_fail++; $display("FAIL load_complete: seq_idle=%0b required 1", seq_idle); end
    endtask

    // Pushes right, left, display on consecutive cycles. The controller keeps
    // busy low for 3 cycles after each issue, then high for 2, then low, so an
    // issue at cycle c is followed by the next at c+7.
    task automatic test_back_to_back();
        logic [2:0] codes [3];
        int last_issue;
        int n_issue;
        logic exp_valid;
        codes[0] = CMD_RIGHT; codes[1] = CMD_LEFT; codes[2] = CMD_DISP;
        last_issue = -100;
        n_issue = 0;
        tick();
        for (int c = 0; c < 23; c++) begin
            host_cmd_valid = (c < 3);
            host_cmd       = (c < 3) ? codes[c] : CMD_DISP;
            busy           = (c - last_issue == 4) || (c - last_issue == 5);
            #1;
            exp_valid = (c == 1) || (c == 8) || (c == 15);
            n_tests++; if (cmd_valid !== exp_valid) begin n_fail++; $display("FAIL b2b_valid: cycle %0d got %0b required %0b", c, cmd_valid, exp_valid); end
            if (exp_valid) begin
                n_tests++; if (cmd !== codes[n_issue]) begin n_fail++; $display("FAIL b2b_order: cycle %0d got %0d required %0d", c, cmd, codes[n_issue]); end
                $display("[TB] b2b issue cmd=%0d cycle=%0d", cmd, c);
                n_issue++;
                last_issue = c;
            end
            if (c == 22) begin
                n_tests++; if (seq_idle !== 1'b1) begin n_fail++; $display("FAIL b2b_idle: seq_idle=%0b required 1", seq_idle); end
            end
            tick();
        end
        host_cmd_valid = 1'b0;
    endtask

    task automatic test_full();
        logic [2:0] codes [4];
        int exp_q[$];
        int got;
        bit done;
        codes[0] = CMD_UP; codes[1] = CMD_DOWN; codes[2] = CMD_RIGHT; codes[3] = CMD_LEFT;
        busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_cmd = codes[i]; host_cmd_valid = 1'b1; #1;
            n_tests++; if (host_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_pre: push %0d ready=%0b required 1", i, host_cmd_ready); end
            n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL full_busy_hold: cmd_valid=%0b required 0", cmd_valid); end
            tick();
        end
        host_cmd = CMD_DISP; host_cmd_valid = 1'b1; #1;
        n_tests++; if (host_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %0b required 0", host_cmd_ready); end
        tick();
        host_cmd_valid = 1'b0; busy = 1'b0; #1;
        n_tests++; if (cmd_valid !== 1'b1 || cmd !== CMD_UP) begin n_fail++; $display("FAIL full_pop: valid=%0b cmd=%0d required 1/4", cmd_valid, cmd); end
        tick();
        busy = 1'b1; #1;
        n_tests++; if (host_cmd_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_after_pop: got %0b required 1", host_cmd_ready); end
        exp_q = '{CMD_DOWN, CMD_RIGHT, CMD_LEFT};
        got = 0;
        done = 1'b0;
        for (int k = 0; k < 120 && !done; k++) begin
            tick();
            busy = k[0]; #1;
            if (cmd_valid) begin
                n_tests++; if (got >= 3 || cmd !== 3'(exp_q[got % 3])) begin n_fail++; $display("FAIL full_drain: issue %0d cmd=%0d required %0d", got, cmd, exp_q[got % 3]); end
                $display("[TB] drain issue cmd=%0d", cmd);
                got++;
            end
            if (seq_idle) done = 1'b1;
        end
        n_tests++; if (got !== 3 || seq_idle !== 1'b1) begin n_fail++; $display("FAIL full_drain_end: issues=%0d idle=%0b required 3/1", got, seq_idle); end
        tick();
        busy = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        busy = 1'b0; host_cmd = CMD_LOAD; host_cmd_valid = 1'b1;
        tick();
        host_cmd_valid = 1'b0; #1;
        n_tests++; if (cmd_valid !== 1'b1 || rom_addr !== 6'd0) begin n_fail++; $display("FAIL rst_load_issue: valid=%0b addr=%0d required 1/0", cmd_valid, rom_addr); end
        tick();
        host_cmd = CMD_UP; host_cmd_valid = 1'b1;
        tick();
        host_cmd_valid = 1'b0;
        for (int k = 0; k < 15; k++) tick();
        #1;
        n_tests++; if (rom_rd !== 1'b1 || rom_addr !== 6'd17) begin n_fail++; $display("FAIL rst_load_at17: rd=%0b addr=%0d required 1/17", rom_rd, rom_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        n_tests++; if (rom_rd !== 1'b0 || rom_addr !== 6'd0) begin n_fail++; $display("FAIL rst_load_rom: rd=%0b addr=%0d required 0/0", rom_rd, rom_addr); end
        n_tests++; if (seq_idle !== 1'b1) begin n_fail++; $display("FAIL rst_load_idle: seq_idle=%0b required 1", seq_idle); end
        tick(); #1;
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_load_discard: cmd_valid=%0b required 0", cmd_valid); end
        $display("[TB] reset during load done");
    endtask

`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
    task automatic test_filter();
        busy = 1'b0; host_cmd = 3'd7; host_cmd_valid = 1'b1; #1;
        n_tests++; if (host_cmd_ready !== 1'b1 || cmd_err !== 1'b0) begin n_fail++; $display("FAIL filter_push7: ready=%0b err=%0b required 1/0", host_cmd_ready, cmd_err); end
        tick();
        host_cmd = CMD_DOWN; #1;
        n_tests++; if (cmd_err !== 1'b1) begin n_fail++; $display("FAIL filter_err: got %0b required 1", cmd_err); end
        n_tests++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL filter_dropped: cmd_valid=%0b required 0", cmd_valid); end
        tick();
        host_cmd_valid = 1'b0; #1;
        n_tests++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL filter_err_pulse: got %0b required 0", cmd_err); end
        n_tests++; if (cmd_valid !== 1'b1 || cmd !== CMD_DOWN) begin n_fail++; $display("FAIL filter_issue: valid=%0b cmd=%0d required 1/5", cmd_valid, cmd); end
        $display("[TB] filter issue cmd=%0d", cmd);
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        tick(); #1;
        n_tests++; if (seq_idle !== 1'b1 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL filter_only_one: idle=%0b valid=%0b required 1/0", seq_idle, cmd_valid); end
    endtask
`else
    task automatic test_code7_queued();
        busy = 1'b0; host_cmd = 3'd7; host_cmd_valid = 1'b1;
        tick();
        host_cmd_valid = 1'b0; #1;
        n_tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd7) begin n_fail++; $display("FAIL code7_issue: valid=%0b cmd=%0d required 1/7", cmd_valid, cmd); end
        $display("[TB] code7 issue cmd=%0d", cmd);
        tick(); #1;
        n_tests++; if (seq_idle !== 1'b0) begin n_fail++; $display("FAIL code7_wait: seq_idle=%0b required 0", seq_idle); end
        tick(); busy = 1'b1;
        tick(); busy = 1'b0;
        tick(); #1;
        n_tests++; if (seq_idle !== 1'b1) begin n_fail++; $display("FAIL code7_done: seq_idle=%0b required 1", seq_idle); end
    endtask
`endif

    // Random host traffic against an LCD model; the reference tracks the
    // queue contents and whether a command is still outstanding (load window,
    // then busy seen high, then busy seen low).
    task automatic test_random();
        int   q_m[$];
        bit   outst;
        bit   seen_hi;
        int   load_left;
        int   prev_idx;
        int   cur_idx;
        bit   err_prev;
        bit   err_now;
        bit   lcd_pend;
        int   lo_cnt;
        int   hi_cnt;
        bit   exp_issue;
        bit   exp_ready;
        bit   exp_idle;
        logic [2:0] exp_cmd;
        int   head;
        outst = 0; seen_hi = 0; load_left = 0; prev_idx = -1; err_prev = 0;
        lcd_pend = 0; lo_cnt = 0; hi_cnt = 0;
        for (int c = 0; c < 600; c++) begin
            host_cmd_valid = (c < 450) && ($urandom_range(0, 1) == 1);
            host_cmd       = 3'($urandom_range(0, 7));
            if (lcd_pend) begin
                if (lo_cnt > 0)      begin busy = 1'b0; lo_cnt--; end
                else if (hi_cnt > 0) begin busy = 1'b1; hi_cnt--; end
                else                 begin busy = 1'b0; lcd_pend = 0; end
            end else begin
                busy = ($urandom_range(0, 4) == 0);
            end
            #1;
            head      = (q_m.size() > 0) ? q_m[0] : 0;
            exp_ready = (q_m.size() < DEPTH);
            exp_issue = !outst && (q_m.size() > 0) && !busy;
            exp_idle  = (q_m.size() == 0) && !outst;
            exp_cmd   = exp_issue ? 3'(head) : 3'd0;
            if (exp_issue && head == 1) cur_idx = 0;
            else if (outst && load_left > 0) cur_idx = IMG_BYTES - load_left;
            else cur_idx = -1;
            n_tests++; if (host_cmd_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_ready: cycle %0d got %0b required %0b", c, host_cmd_ready, exp_ready); end
            n_tests++; if (seq_idle !== exp_idle) begin n_fail++; $display("FAIL rnd_idle: cycle %0d got %0b required %0b", c, seq_idle, exp_idle); end
            n_tests++; if (cmd_valid !== exp_issue || cmd !== exp_cmd) begin n_fail++; $display("FAIL rnd_cmd: cycle %0d valid=%0b cmd=%0d required %0b/%0d", c, cmd_valid, cmd, exp_issue, exp_cmd); end
            n_tests++; if (rom_rd !== (cur_idx >= 0) || rom_addr !== ((cur_idx >= 0) ? 6'(cur_idx) : 6'd0)) begin n_fail++; $display("FAIL rnd_rom: cycle %0d rd=%0b addr=%0d required idx %0d", c, rom_rd, rom_addr, cur_idx); end
            if (prev_idx >= 0) begin
                n_tests++; if (datain !== rom_mem[prev_idx]) begin n_fail++; $display("FAIL rnd_data: cycle %0d got %02h required %02h", c, datain, rom_mem[prev_idx]); end
            end
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
            n_tests++; if (cmd_err !== err_prev) begin n_fail++; $display("FAIL rnd_err: cycle %0d got %0b required %0b", c, cmd_err, err_prev); end
`endif
            // End-of-cycle model update.
            if (exp_issue) begin
                void'(q_m.pop_front());
                outst = 1; seen_hi = 0;
                load_left = (head == 1) ? IMG_BYTES - 1 : 0;
                lcd_pend = 1;
                lo_cnt = $urandom_range(0, 3) + ((head == 1) ? IMG_BYTES : 0);
                hi_cnt = $urandom_range(1, 3);
                $display("[TB] rnd issue cmd=%0d cycle=%0d", head, c);
            end else if (outst) begin
                if (load_left > 0) load_left--;
                else if (!seen_hi) begin if (busy) seen_hi = 1; end
                else if (!busy) outst = 0;
            end
            err_now = 0;
            if (host_cmd_valid && exp_ready) begin
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
                if (host_cmd >= 3'd6) err_now = 1;
                else q_m.push_back(int'(host_cmd));
`else
                q_m.push_back(int'(host_cmd));
`endif
            end
            err_prev = err_now;
            prev_idx = cur_idx;
            tick();
        end
        host_cmd_valid = 1'b0;
        #1;
        n_tests++; if (seq_idle !== ((q_m.size() == 0) && !outst)) begin n_fail++; $display("FAIL rnd_final_idle: got %0b", seq_idle); end
    endtask

    initial begin
        for (int i = 0; i < IMG_BYTES; i++) rom_mem[i] = 8'($urandom);
        reset = 1'b1; busy = 1'b0; host_cmd = 3'd0; host_cmd_valid = 1'b0;
        tick();
        test_reset();
        test_load();
        test_back_to_back();
        test_full();
        test_reset_mid_load();
`ifdef LCD_HOST_SEQ_CMD_FILTER_EN
        test_filter();
`else
        test_code7_queued();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
